// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: bundle between the multicycle control unit and its datapath.
// Decode fields and the ALU zero flag travel from the datapath to the control
// unit. Every control strobe and the debug/status outputs travel back.
//   master : control unit side (drives strobes, reads op/funct/zero)
//   slave  : datapath/observer side
interface mc_ctrl_if;
  logic [5:0]  op_i;
  logic [5:0]  funct_i;
  logic        zero_i;
  logic        initial_sel;
  logic        PCWrite;
  logic        IorD;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        RegWrite;
  logic        ALUSrcA;
  logic        PCSrc;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [3:0]  state_o;
  logic        illegal_o;
  logic [31:0] instr_count_o;

  modport master (
    input  op_i, funct_i, zero_i,
    output initial_sel, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, PCSrc, ALUSrcB, ALUControl, state_o, illegal_o,
           instr_count_o
  );
  modport slave (
    output op_i, funct_i, zero_i,
    input  initial_sel, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, PCSrc, ALUSrcB, ALUControl, state_o, illegal_o,
           instr_count_o
  );
endinterface

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS control FSM.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   bus         : mc_ctrl_if.master (op/funct/zero in; strobes, state_o,
//                 illegal_o, instr_count_o out)
// Parameter INIT_CYCLES (1..15): cycles spent in INIT before the first FETCH.
// Optional feature: define MC_CU_INSTR_COUNT_EN for the retired-instruction
// counter; otherwise instr_count_o is tied to 0.
// Strobes are registered from the next state, so they change with state_o.
// The one exception is PCWrite in BRANCH, which follows zero_i directly.
module mc_control_unit #(
  parameter int unsigned INIT_CYCLES = 1
) (
  input logic      clk,
  input logic      reset,
  mc_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
    S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       initial_sel;
    logic       pc_write;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_src;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
  } ctrl_t;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     state, nxt;
  ctrl_t      ctl;
  logic [3:0] init_cnt;
  logic       illegal;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       op_ok;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct_i)
      6'h20: funct_alu = ALU_ADD;
      6'h22: funct_alu = ALU_SUB;
      6'h24: funct_alu = ALU_AND;
      6'h25: funct_alu = ALU_OR;
      6'h27: funct_alu = ALU_NOR;
      6'h2A: funct_alu = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    op_ok = 1'b1;
    nxt   = state;
    case (state)
      S_INIT:   nxt = (init_cnt == INIT_LAST) ? S_FETCH : S_INIT;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (bus.op_i)
          6'h23, 6'h2B: nxt = S_MEMADR;
          6'h04:        nxt = S_BRANCH;
          6'h08:        nxt = S_ADDIEX;
          6'h00: begin
            nxt   = funct_ok ? S_EXEC : S_FETCH;
            op_ok = funct_ok;
          end
          default: begin
            nxt   = S_FETCH;
            op_ok = 1'b0;
          end
        endcase
      end
      S_MEMADR: nxt = (bus.op_i == 6'h2B) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = S_MEMWB;
      S_EXEC:   nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      default:  nxt = S_FETCH;  // MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, unused
    endcase
  end

  // Strobes for a state; alu_r is only consumed in EXEC.
  function automatic ctrl_t decode_out(state_t s, logic [3:0] alu_r);
    ctrl_t c;
    c = '0;
    c.initial_sel = (s != S_INIT);
    case (s)
      S_INIT:   c.pc_write = 1'b1;
      S_FETCH:  begin c.ir_write = 1'b1; c.pc_write = 1'b1;
                      c.alu_src_b = 2'b01; c.alu_ctl = ALU_ADD; end
      S_DECODE: begin c.alu_src_b = 2'b11; c.alu_ctl = ALU_ADD; end
      S_MEMADR, S_ADDIEX:
                begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctl = ALU_ADD; end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_ctl = alu_r; end
      S_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_ctl = ALU_SUB; c.pc_src = 1'b1; end
      S_ADDIWB: c.reg_write = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
      illegal  <= 1'b0;
      ctl      <= decode_out(S_INIT, ALU_ADD);
    end else begin
      state <= nxt;
      ctl   <= decode_out(nxt, funct_alu);
      if (state == S_INIT) init_cnt <= init_cnt + 4'd1;
      if (state == S_DECODE && !op_ok) illegal <= 1'b1;
    end
  end

`ifdef MC_CU_INSTR_COUNT_EN
  logic [31:0] icnt;
  logic        retire;
  assign retire = (nxt == S_FETCH) &&
                  (state == S_MEMWB || state == S_MEMWR || state == S_ALUWB ||
                   state == S_BRANCH || state == S_ADDIWB);
  always_ff @(posedge clk) begin
    if (reset)       icnt <= '0;
    else if (retire) icnt <= icnt + 32'd1;
  end
  assign bus.instr_count_o = icnt;
`else
  assign bus.instr_count_o = '0;
`endif

  assign bus.initial_sel = ctl.initial_sel;
  assign bus.PCWrite     = ctl.pc_write | ((state == S_BRANCH) & bus.zero_i);
  assign bus.IorD        = ctl.iord;
  assign bus.MemWrite    = ctl.mem_write;
  assign bus.IRWrite     = ctl.ir_write;
  assign bus.RegDst      = ctl.reg_dst;
  assign bus.MemtoReg    = ctl.mem_to_reg;
  assign bus.RegWrite    = ctl.reg_write;
  assign bus.ALUSrcA     = ctl.alu_src_a;
  assign bus.PCSrc       = ctl.pc_src;
  assign bus.ALUSrcB     = ctl.alu_src_b;
  assign bus.ALUControl  = ctl.alu_ctl;
  assign bus.state_o     = state;
  assign bus.illegal_o   = illegal;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed checks of the multicycle control FSM.
module tb_mc_control_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] exp_cnt = 0;

  mc_ctrl_if bus ();
  mc_control_unit #(.INIT_CYCLES(1)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.op_i = 6'h00; bus.funct_i = 6'h20; bus.zero_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.state_o !== 4'd0 || bus.PCWrite !== 1'b1 || bus.initial_sel !== 1'b0 ||
          bus.IRWrite !== 1'b0 || bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0 ||
          bus.illegal_o !== 1'b0 || bus.instr_count_o !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_cycle%0d: state=%0d PCWrite=%b initial_sel=%b IRWrite=%b RegWrite=%b MemWrite=%b ill=%b cnt=%0d, want 0 1 0 0 0 0 0 0",
                 i, bus.state_o, bus.PCWrite, bus.initial_sel, bus.IRWrite, bus.RegWrite,
                 bus.MemWrite, bus.illegal_o, bus.instr_count_o);
      end
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.state_o !== 4'd0 || bus.PCWrite !== 1'b1 || bus.initial_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL init_cycle: state=%0d PCWrite=%b initial_sel=%b, want 0 1 0",
               bus.state_o, bus.PCWrite, bus.initial_sel);
    end
    tick();
    n_chk++;
    if (bus.state_o !== 4'd1 || bus.IRWrite !== 1'b1 || bus.ALUSrcB !== 2'b01 ||
        bus.PCWrite !== 1'b1 || bus.initial_sel !== 1'b1 || bus.ALUControl !== 4'b0010) begin
      n_fail++;
      $display("FAIL first_fetch: state=%0d IRWrite=%b ALUSrcB=%b PCWrite=%b initial_sel=%b ALUControl=%b, want 1 1 01 1 1 0010",
               bus.state_o, bus.IRWrite, bus.ALUSrcB, bus.PCWrite, bus.initial_sel, bus.ALUControl);
    end
    exp_cnt = 0;
  endtask

  task automatic test_lw;
    logic [3:0] seq [5];
    seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    bus.op_i = 6'h23;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (bus.state_o !== seq[i] ||
          bus.MemtoReg !== (seq[i] == 4'd5) || bus.RegWrite !== (seq[i] == 4'd5)) begin
        n_fail++;
        $display("FAIL lw_step%0d: state=%0d MemtoReg=%b RegWrite=%b, want state %0d",
                 i, bus.state_o, bus.MemtoReg, bus.RegWrite, seq[i]);
      end
    end
`ifdef MC_CU_INSTR_COUNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    n_chk++;
    if (bus.instr_count_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL lw_count: got %0d want %0d", bus.instr_count_o, exp_cnt);
    end
  endtask

  task automatic test_rtype_sw;
    bus.op_i = 6'h00; bus.funct_i = 6'h22;
    tick();
    tick();
    n_chk++;
    if (bus.state_o !== 4'd7 || bus.ALUControl !== 4'b0110 || bus.ALUSrcA !== 1'b1 ||
        bus.ALUSrcB !== 2'b00 || bus.RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_exec: state=%0d ALUControl=%b ALUSrcA=%b ALUSrcB=%b RegWrite=%b, want 7 0110 1 00 0",
               bus.state_o, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite);
    end
    tick();
    n_chk++;
    if (bus.state_o !== 4'd8 || bus.RegDst !== 1'b1 || bus.RegWrite !== 1'b1 || bus.MemtoReg !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_aluwb: state=%0d RegDst=%b RegWrite=%b MemtoReg=%b, want 8 1 1 0",
               bus.state_o, bus.RegDst, bus.RegWrite, bus.MemtoReg);
    end
    tick();
    n_chk++;
    if (bus.state_o !== 4'd1) begin
      n_fail++;
      $display("FAIL sub_back_to_fetch: state=%0d want 1", bus.state_o);
    end
    bus.op_i = 6'h2B;
    tick();
    tick();
    n_chk++;
    if (bus.state_o !== 4'd3 || bus.MemWrite !== 1'b0 || bus.ALUSrcB !== 2'b10) begin
      n_fail++;
      $display("FAIL sw_memadr: state=%0d MemWrite=%b ALUSrcB=%b, want 3 0 10",
               bus.state_o, bus.MemWrite, bus.ALUSrcB);
    end
    tick();
    n_chk++;
    if (bus.state_o !== 4'd6 || bus.MemWrite !== 1'b1 || bus.IorD !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_memwr: state=%0d MemWrite=%b IorD=%b, want 6 1 1",
               bus.state_o, bus.MemWrite, bus.IorD);
    end
    tick();
`ifdef MC_CU_INSTR_COUNT_EN
    exp_cnt = exp_cnt + 2;
`endif
    n_chk++;
    if (bus.state_o !== 4'd1 || bus.MemWrite !== 1'b0 || bus.instr_count_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL sw_done: state=%0d MemWrite=%b cnt=%0d, want 1 0 %0d",
               bus.state_o, bus.MemWrite, bus.instr_count_o, exp_cnt);
    end
  endtask

  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      bus.op_i = 6'h04; bus.zero_i = z[0];
      tick();
      tick();
      n_chk++;
      if (bus.state_o !== 4'd9 || bus.PCWrite !== z[0] || bus.PCSrc !== 1'b1 ||
          bus.ALUControl !== 4'b0110 || bus.ALUSrcA !== 1'b1) begin
        n_fail++;
        $display("FAIL beq_z%0d: state=%0d PCWrite=%b PCSrc=%b ALUControl=%b, want 9 %0d 1 0110",
                 z, bus.state_o, bus.PCWrite, bus.PCSrc, bus.ALUControl, z);
      end
      tick();
`ifdef MC_CU_INSTR_COUNT_EN
      exp_cnt = exp_cnt + 1;
`endif
      n_chk++;
      if (bus.state_o !== 4'd1 || bus.instr_count_o !== exp_cnt) begin
        n_fail++;
        $display("FAIL beq_z%0d_len: state=%0d cnt=%0d, want 1 %0d",
                 z, bus.state_o, bus.instr_count_o, exp_cnt);
      end
    end
    bus.zero_i = 1'b1;  // ignored outside BRANCH
    #1;
    n_chk++;
    if (bus.PCWrite !== 1'b1 || bus.PCSrc !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_ignored_fetch: PCWrite=%b PCSrc=%b, want 1 0", bus.PCWrite, bus.PCSrc);
    end
    bus.zero_i = 1'b0;
  endtask

  task automatic test_illegal;
    bus.op_i = 6'h3F;
    tick();
    tick();
    n_chk++;
    if (bus.state_o !== 4'd1 || bus.illegal_o !== 1'b1 || bus.instr_count_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL illegal_op: state=%0d ill=%b cnt=%0d, want 1 1 %0d",
               bus.state_o, bus.illegal_o, bus.instr_count_o, exp_cnt);
    end
    bus.op_i = 6'h08;
    tick();
    tick();
    n_chk++;
    if (bus.state_o !== 4'd10 || bus.ALUSrcB !== 2'b10 || bus.ALUSrcA !== 1'b1 || bus.RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_ex: state=%0d ALUSrcB=%b ALUSrcA=%b RegWrite=%b, want 10 10 1 0",
               bus.state_o, bus.ALUSrcB, bus.ALUSrcA, bus.RegWrite);
    end
    tick();
    n_chk++;
    if (bus.state_o !== 4'd11 || bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b0 || bus.MemtoReg !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_wb: state=%0d RegWrite=%b RegDst=%b MemtoReg=%b, want 11 1 0 0",
               bus.state_o, bus.RegWrite, bus.RegDst, bus.MemtoReg);
    end
    tick();
`ifdef MC_CU_INSTR_COUNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    n_chk++;
    if (bus.state_o !== 4'd1 || bus.illegal_o !== 1'b1 || bus.instr_count_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL illegal_sticky: state=%0d ill=%b cnt=%0d, want 1 1 %0d",
               bus.state_o, bus.illegal_o, bus.instr_count_o, exp_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if (bus.illegal_o !== 1'b0 || bus.state_o !== 4'd0 || bus.instr_count_o !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_cleared: ill=%b state=%0d cnt=%0d, want 0 0 0",
               bus.illegal_o, bus.state_o, bus.instr_count_o);
    end
    exp_cnt = 0;
    tick();
    // R-type with an unsupported funct is illegal too
    bus.op_i = 6'h00; bus.funct_i = 6'h3F;
    tick();
    tick();
    n_chk++;
    if (bus.state_o !== 4'd1 || bus.illegal_o !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_funct: state=%0d ill=%b, want 1 1", bus.state_o, bus.illegal_o);
    end
  endtask

  task automatic test_reset_memwr;
    bus.op_i = 6'h2B;
    tick();
    tick();
    tick();
    n_chk++;
    if (bus.state_o !== 4'd6 || bus.MemWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_abort_memwr: state=%0d MemWrite=%b, want 6 1", bus.state_o, bus.MemWrite);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if (bus.state_o !== 4'd0 || bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0 ||
        bus.PCWrite !== 1'b1 || bus.instr_count_o !== 32'd0 || bus.illegal_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_memwr: state=%0d MemWrite=%b RegWrite=%b PCWrite=%b cnt=%0d ill=%b, want 0 0 0 1 0 0",
               bus.state_o, bus.MemWrite, bus.RegWrite, bus.PCWrite, bus.instr_count_o, bus.illegal_o);
    end
    exp_cnt = 0;
    tick();
    n_chk++;
    if (bus.state_o !== 4'd1) begin
      n_fail++;
      $display("FAIL abort_refetch: state=%0d want 1", bus.state_o);
    end
  endtask

  task automatic test_count;
    // 10 instructions: 5 addi (4 cycles) and 5 beq (3 cycles)
    for (int k = 0; k < 10; k++) begin
      bus.op_i = (k % 2 == 0) ? 6'h08 : 6'h04;
      for (int c = 0; c < ((k % 2 == 0) ? 4 : 3); c++) tick();
`ifdef MC_CU_INSTR_COUNT_EN
      exp_cnt = exp_cnt + 1;
`endif
    end
    n_chk++;
    if (bus.state_o !== 4'd1 || bus.instr_count_o !== exp_cnt) begin
      n_fail++;
      $display("FAIL count_10: state=%0d cnt=%0d, want 1 %0d", bus.state_o, bus.instr_count_o, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_sw();
    test_beq();
    test_illegal();
    test_reset_memwr();
    test_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
